// File: rtl/fetch_ctrl_if.sv
// Memory read bus between the fetch controller and instruction memory.
//   mem_req   : read request, held high until mem_ack
//   mem_addr  : read address (AW bits)
//   mem_ack   : read data valid this cycle
//   mem_rdata : 16-bit read data
// master = fetch controller, slave = memory.
interface fetch_ctrl_if #(
    parameter int unsigned AW = 12
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the program counter, issues memory
// reads, hands fetched words to the instruction register, halts on HLT_OP
// and aborts a read that is not acknowledged within TIMEOUT cycles.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   mem          : memory read bus (master side)
//   start        : begin/resume fetching (IDLE or HALT)
//   stop         : return to IDLE after the current load
//   branch       : load pc from branch_addr
//   branch_addr  : branch target
//   inIR         : fetched instruction word
//   irLD, irCLR  : one-cycle load / clear strobes for the instruction register
//   pc           : program counter
//   busy, halted : state flags (REQ/LOAD, HALT)
//   err          : sticky read-timeout flag
module fetch_ctrl #(
    parameter int unsigned AW      = 12,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [15:0] HLT_OP  = 16'h7001
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_ctrl_if.master  mem,
    input  logic          start,
    input  logic          stop,
    input  logic          branch,
    input  logic [AW-1:0] branch_addr,
    output logic [15:0]   inIR,
    output logic          irLD,
    output logic          irCLR,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;

    // State-decoded outputs: they drop as soon as reset forces IDLE.
    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = pc;
    assign irLD         = (state == LOAD);
    assign busy         = (state == REQ) || (state == LOAD);
    assign halted       = (state == HALT);

    // Fetch sequencing, pc update, timeout and error tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            pc    <= '0;
            inIR  <= '0;
            tcnt  <= '0;
            irCLR <= 1'b0;
            err   <= 1'b0;
        end else begin
            irCLR <= 1'b0;
            case (state)
                IDLE: begin
                    if (branch) pc <= branch_addr;
                    if (start) begin
                        state <= REQ;
                        tcnt  <= '0;
                        err   <= 1'b0;
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still wins over the abort.
                    if (mem.mem_ack) begin
                        inIR  <= mem.mem_rdata;
                        state <= LOAD;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                        irCLR <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                LOAD: begin
                    pc <= branch ? branch_addr : pc + AW'(1);
                    if (inIR == HLT_OP) begin
                        state <= HALT;
                    end else if (stop) begin
                        state <= IDLE;
                    end else begin
                        state <= REQ;
                        tcnt  <= '0;
                    end
                end
                HALT: begin
                    if (branch) pc <= branch_addr;
                    if (start) begin
                        state <= REQ;
                        tcnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter AW SHALL be: AW, 12, address and program-counter width.
REQ-002 Parameter TIMEOUT SHALL be: TIMEOUT, 16, maximum cycles in REQ without mem_ack before abort.
REQ-003 Parameter HLT_OP SHALL be: HLT_OP, 16'h7001, instruction word that halts fetching.
REQ-004 Port SHALL be: CLK  in  1  single clock, all state updates on posedge.
REQ-005 Port SHALL be: RST  in  1  asynchronous, active-high reset.
REQ-006 Port SHALL be: start  in  1  begin or resume fetching, sampled in IDLE or HALT.
REQ-007 Port SHALL be: stop  in  1  return to IDLE after the current load.
REQ-008 Port SHALL be: branch  in  1  load pc from branch_addr.
REQ-009 Port SHALL be: branch_addr  in  AW  branch target.
REQ-010 Port SHALL be: mem_ack  in  1  memory read data valid this cycle.
REQ-011 Port SHALL be: mem_rdata  in  16  memory read data.
REQ-012 Port SHALL be: mem_req  out  1  read request, held high until mem_ack.
REQ-013 Port SHALL be: mem_addr  out  AW  read address, equal to pc while mem_req is high.
REQ-014 Port SHALL be: inIR  out  16  registered instruction word for the instruction register.
REQ-015 Port SHALL be: irLD  out  1  one-cycle load strobe for the instruction register.
REQ-016 Port SHALL be: irCLR  out  1  one-cycle clear strobe for the instruction register.
REQ-017 Port SHALL be: pc  out  AW  program counter.
REQ-018 Port SHALL be: busy  out  1  high in REQ and LOAD.
REQ-019 Port SHALL be: halted  out  1  high in HALT.
REQ-020 Port SHALL be: err  out  1  sticky timeout flag.

Function
REQ-021 FSM states SHALL be IDLE, REQ, LOAD, HALT; all outputs are registered or decoded from state only.
REQ-022 IDLE: start=1 -> REQ next cycle; branch=1 -> pc<=branch_addr at the same edge.
REQ-023 REQ: mem_req=1, mem_addr=pc; mem_ack=1 at an edge -> inIR<=mem_rdata, state LOAD.
REQ-024 LOAD: irLD=1 for exactly one cycle; at its closing edge pc<=pc+1, or branch_addr if branch=1 (branch wins).
REQ-025 LOAD exit priority SHALL be: inIR==HLT_OP -> HALT; else stop=1 -> IDLE; else -> REQ.
REQ-026 HALT: start=1 -> REQ; branch in HALT loads pc as in IDLE; other inputs ignored.
REQ-027 pc increment SHALL wrap modulo 2^AW (all-ones -> 0) with no flag.
REQ-028 Minimum latency SHALL be: start edge -> mem_req next cycle; ack in that cycle -> irLD in the following cycle; back-to-back fetch = 2 cycles per instruction.
REQ-029 Timeout counter SHALL clear on entering REQ and count REQ cycles; reaching TIMEOUT without mem_ack -> IDLE, irCLR=1 for one cycle, err<=1, pc unchanged.
REQ-030 mem_ack on the same edge the counter reaches TIMEOUT SHALL count as success (no error).
REQ-031 err SHALL clear only on RST or on a start accepted in IDLE.
REQ-032 mem_ack outside REQ SHALL be ignored; branch in REQ SHALL be ignored.
REQ-033 start and branch together in IDLE SHALL load pc with branch_addr and fetch from it first.
REQ-034 stop outside LOAD SHALL be ignored.

Reset
REQ-035 RST=1 SHALL immediately force state IDLE, pc=0, inIR=0, timeout counter=0, and mem_req, irLD, irCLR, busy, halted, err=0, regardless of CLK.
REQ-036 RST asserted mid-REQ SHALL drop mem_req in the same cycle; a later mem_ack SHALL have no effect.
REQ-037 After RST release, no request SHALL be issued until start is sampled high.

Verification
REQ-038 Reset, start, ack=1 with rdata=16'h2005 on the first REQ cycle -> mem_addr=0, irLD high one cycle, inIR=16'h2005, pc=1.
REQ-039 Three fetches, each with a 3-cycle ack delay -> mem_addr 0,1,2; irLD pulses 4 cycles apart; pc=3.
REQ-040 branch_addr=12'hFFF with start in IDLE, then two fetches -> addresses FFF then 000 (wrap); pc=001.
REQ-041 rdata=HLT_OP -> irLD pulse, then halted=1 and mem_req=0; start -> next fetch at pc.
REQ-042 mem_ack withheld for 16 cycles -> irCLR one cycle, err=1, state IDLE; next accepted start clears err.
REQ-043 RST pulsed mid-REQ between clock edges -> mem_req and all outputs 0 at once; a late ack leaves inIR=0.
